// File: rtl/bit_scan_iterator.sv
// Streaming set-bit iterator: accepts a WIDTH-bit word and emits one beat per
// set bit (one-hot, index, last), scanning LSB-first or MSB-first per word.
module bit_scan_iterator #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [WIDTH-1:0] bit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic             empty_o,
  output logic             data_val_o,
  input  logic             data_ready_i
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] residue_q, residue_d;
  logic [WIDTH-1:0] bit_q, bit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             empty_q, empty_d;
  logic             val_q, val_d;
  logic             dir_q, dir_d;

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] src;
  logic             src_dir;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_bit;
  logic [WIDTH-1:0] rem;

  // Lowest set bit keeps the first hit; highest keeps the last hit.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [WIDTH-1:0] v,
                                                 input logic msb_first);
    logic [IDX_W-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i] && (msb_first || !found)) begin
        r     = IDX_W'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign consume      = val_q && data_ready_i;
  assign data_ready_o = (state_q == IDLE) || (consume && last_q);
  assign accept       = data_val_i && data_ready_o;

  // A fresh word and a residue step share one selector.
  always_comb begin
    src     = accept ? data_i : residue_q;
    src_dir = accept ? dir_i : dir_q;
    sel_idx = pick_idx(src, src_dir);
    sel_bit = '0;
    if (src != '0) begin
      sel_bit[sel_idx] = 1'b1;
    end
    rem = src & ~sel_bit;
  end

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    last_d    = last_q;
    empty_d   = empty_q;
    val_d     = val_q;
    dir_d     = dir_q;

    if (accept) begin
      state_d   = BUSY;
      val_d     = 1'b1;
      dir_d     = dir_i;
      bit_d     = sel_bit;
      idx_d     = sel_idx;
      residue_d = rem;
      last_d    = (rem == '0);
      empty_d   = (data_i == '0);
    end else if (consume) begin
      if (last_q) begin
        state_d = IDLE;
        val_d   = 1'b0;
      end else begin
        bit_d     = sel_bit;
        idx_d     = sel_idx;
        residue_d = rem;
        last_d    = (rem == '0);
        empty_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      residue_q <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      empty_q   <= 1'b0;
      val_q     <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      empty_q   <= empty_d;
      val_q     <= val_d;
      dir_q     <= dir_d;
    end
  end

  assign bit_o      = bit_q;
  assign idx_o      = idx_q;
  assign last_o     = last_q;
  assign empty_o    = empty_q;
  assign data_val_o = val_q;

endmodule

// File: tb/tb_bit_scan_iterator.sv
// Directed bench for bit_scan_iterator: inputs driven and outputs sampled on
// the falling clock edge, expected values hand-derived.
module tb_bit_scan_iterator;

  logic        clk;
  logic        arst_n;
  logic [15:0] data;
  logic        dir;
  logic        val_in;
  logic        ready_out;
  logic [15:0] bit_out;
  logic [3:0]  idx_out;
  logic        last_out;
  logic        empty_out;
  logic        val_out;
  logic        ready_in;

  int checks = 0;
  int errors = 0;

  bit_scan_iterator #(.WIDTH(16)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .data_i      (data),
    .dir_i       (dir),
    .data_val_i  (val_in),
    .data_ready_o(ready_out),
    .bit_o       (bit_out),
    .idx_o       (idx_out),
    .last_o      (last_out),
    .empty_o     (empty_out),
    .data_val_o  (val_out),
    .data_ready_i(ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    arst_n = 1'b0; data = '0; dir = 1'b0; val_in = 1'b0; ready_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({val_out, last_out, empty_out} !== 3'b000 || bit_out !== 16'h0 || idx_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: val=%b last=%b empty=%b bit=%h idx=%0d, required all 0",
               val_out, last_out, empty_out, bit_out, idx_out);
    end
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b, required 1", ready_out);
    end
  endtask

  task automatic test_reset_midword;
    data = 16'h00F0; dir = 1'b0; val_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
    @(negedge clk);
    checks++;
    if (val_out !== 1'b1 || idx_out !== 4'd5) begin
      errors++;
      $display("FAIL midword_second_beat: val=%b idx=%0d, required val=1 idx=5", val_out, idx_out);
    end
    ready_in = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (val_out !== 1'b0 || bit_out !== 16'h0 || idx_out !== 4'd0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL midword_async_reset: val=%b bit=%h idx=%0d last=%b, required 0",
               val_out, bit_out, idx_out, last_out);
    end
    @(negedge clk);
    arst_n = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || val_out !== 1'b0) begin
      errors++;
      $display("FAIL midword_release: ready=%b val=%b, required ready=1 val=0", ready_out, val_out);
    end
    data = 16'h0003; val_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
    checks++;
    if (val_out !== 1'b1 || idx_out !== 4'd0 || last_out !== 1'b0) begin
      errors++;
      $display("FAIL fresh_beat0: val=%b idx=%0d last=%b, required 1/0/0", val_out, idx_out, last_out);
    end
    @(negedge clk);
    checks++;
    if (val_out !== 1'b1 || idx_out !== 4'd1 || last_out !== 1'b1) begin
      errors++;
      $display("FAIL fresh_beat1: val=%b idx=%0d last=%b, required 1/1/1", val_out, idx_out, last_out);
    end
    @(negedge clk);
  endtask

  task automatic test_scan(input logic d);
    int          exp_idx[4];
    logic [15:0] exp_bit[4];
    if (!d) begin
      exp_idx = '{0, 5, 10, 15};
      exp_bit = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};
    end else begin
      exp_idx = '{15, 10, 5, 0};
      exp_bit = '{16'h8000, 16'h0400, 16'h0020, 16'h0001};
    end
    data = 16'h8421; dir = d; val_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0; dir = ~d; data = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (val_out !== 1'b1 || idx_out !== 4'(exp_idx[k]) || bit_out !== exp_bit[k] ||
          last_out !== (k == 3) || empty_out !== 1'b0 || ready_out !== (k == 3)) begin
        errors++;
        $display("FAIL scan_dir%0b_beat%0d: val=%b idx=%0d bit=%h last=%b empty=%b ready=%b, required 1 %0d %h %b 0 %b",
                 d, k, val_out, idx_out, bit_out, last_out, empty_out, ready_out,
                 exp_idx[k], exp_bit[k], (k == 3), (k == 3));
      end
      @(negedge clk);
    end
    checks++;
    if (val_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL scan_dir%0b_idle: val=%b ready=%b, required 0/1", d, val_out, ready_out);
    end
  endtask

  task automatic test_empty;
    data = 16'h0000; dir = 1'b0; val_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0;
    checks++;
    if (val_out !== 1'b1 || bit_out !== 16'h0 || idx_out !== 4'd0 || empty_out !== 1'b1 ||
        last_out !== 1'b1) begin
      errors++;
      $display("FAIL empty_beat: val=%b bit=%h idx=%0d empty=%b last=%b, required 1 0000 0 1 1",
               val_out, bit_out, idx_out, empty_out, last_out);
    end
    @(negedge clk);
    checks++;
    if (val_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL empty_idle: val=%b ready=%b, required 0/1", val_out, ready_out);
    end
  endtask

  task automatic test_backpressure;
    data = 16'h0003; dir = 1'b0; val_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    val_in = 1'b0; ready_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (val_out !== 1'b1 || bit_out !== 16'h0001 || idx_out !== 4'd0 || last_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_cycle%0d: val=%b bit=%h idx=%0d last=%b, required 1 0001 0 0",
                 c, val_out, bit_out, idx_out, last_out);
      end
      if (c == 2) ready_in = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (val_out !== 1'b1 || bit_out !== 16'h0002 || idx_out !== 4'd1 || last_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_beat: val=%b bit=%h idx=%0d last=%b, required 1 0002 1 1",
               val_out, bit_out, idx_out, last_out);
    end
    @(negedge clk);
    checks++;
    if (val_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: val=%b, required 0", val_out);
    end
  endtask

  task automatic test_back_to_back;
    int          exp_idx;
    logic        exp_last;
    logic        exp_ready;
    logic [15:0] exp_bit;
    data = 16'hFFFF; dir = 1'b0; val_in = 1'b1; ready_in = 1'b1;
    @(negedge clk);
    data = 16'h0001;
    for (int k = 0; k < 17; k++) begin
      exp_idx   = (k < 16) ? k : 0;
      exp_bit   = 16'h0001 << exp_idx;
      exp_last  = (k >= 15);
      exp_ready = (k >= 15);
      checks++;
      if (val_out !== 1'b1 || idx_out !== 4'(exp_idx) || bit_out !== exp_bit ||
          last_out !== exp_last || ready_out !== exp_ready || empty_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b_beat%0d: val=%b idx=%0d bit=%h last=%b ready=%b empty=%b, required 1 %0d %h %b %b 0",
                 k, val_out, idx_out, bit_out, last_out, ready_out, empty_out,
                 exp_idx, exp_bit, exp_last, exp_ready);
      end
      if (k == 16) val_in = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (val_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: val=%b ready=%b, required 0/1", val_out, ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midword();
    test_scan(1'b0);
    test_scan(1'b1);
    test_empty();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
